udp_tx_scheduler: RTL and testbench

//  Arbitrates the single UDP transmit path between all outbound packet sources:

---
 rtl/udp_tx_sched_pkg.sv | 18 +
 rtl/udp_tx_scheduler_rr_arbiter.sv | 35 +++
 rtl/udp_tx_scheduler.sv | 134 +++++++++++++
 tb/tb_udp_tx_scheduler.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_tx_sched_pkg.sv
// Shared source codes and FSM encoding for the UDP transmit scheduler.
package udp_tx_sched_pkg;

    localparam logic [2:0] SRC_NONE = 3'd0;
    localparam logic [2:0] SRC_RESP = 3'd1;
    localparam logic [2:0] SRC_CC   = 3'd2;
    localparam logic [2:0] SRC_MIC  = 3'd3;
    localparam logic [2:0] SRC_WB   = 3'd4;
    localparam logic [2:0] SRC_RX   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2,
        ST_GAP   = 2'd3
    } sched_state_t;

endpackage

// File: rtl/udp_tx_scheduler_rr_arbiter.sv
// Combinational rotate-priority encoder: first set req bit at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 8,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          any_req,
    output logic [PW-1:0] idx
);

    localparam logic [PW:0] NW = (PW+1)'(N);

    logic [N-1:0]  rot;
    logic [PW-1:0] off;
    logic [PW:0]   sum;
    logic          found;

    always_comb begin
        // rot[i] is req[(ptr + i) mod N], so bit 0 is the highest-priority slot
        rot   = N'({req, req} >> ptr);
        found = 1'b0;
        off   = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = PW'(i);
            end
        end
        sum     = {1'b0, ptr} + {1'b0, off};
        idx     = (sum >= NW) ? PW'(sum - NW) : sum[PW-1:0];
        any_req = found;
    end

endmodule

// File: rtl/udp_tx_scheduler.sv
// Single-grant arbiter for the UDP transmit path: fixed class priority, Rx round-robin,
// Rx starvation promotion, post-packet gap and a hang timeout on open grants.
module udp_tx_scheduler
    import udp_tx_sched_pkg::*;
#(
    parameter int NR           = 8,
    parameter int STARVE_LIMIT = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int TIMEOUT      = 4095
) (
    input  logic                  tx_clock,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic                  wideband,
    input  logic                  resp_req,
    input  logic                  cc_req,
    input  logic                  mic_req,
    input  logic                  wb_req,
    input  logic [NR-1:0]         rx_req,
    input  logic                  send_done,
    output logic                  grant_valid,
    output logic [2:0]            grant_src,
    output logic [$clog2(NR):0]   grant_rx,
    output logic                  sched_timeout
);

    localparam int PW       = (NR > 1) ? $clog2(NR) : 1;
    localparam int RXW      = $clog2(NR) + 1;
    localparam int SW       = $clog2(STARVE_LIMIT + 1);
    localparam int TW       = $clog2(TIMEOUT + 1);
    localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [SW-1:0] SL      = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TO_FULL = TW'(TIMEOUT);
    localparam logic [GW-1:0] GL      = GW'(GAP_LAST);
    localparam logic [PW:0]   NRW     = (PW+1)'(NR);

    sched_state_t  state;
    logic [PW-1:0] rr_ptr;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] to_cnt;
    logic [GW-1:0] gap_cnt;

    logic          rx_any;
    logic [PW-1:0] rx_idx;
    logic [PW:0]   rx_inc;
    logic [PW-1:0] rr_next;
    logic [2:0]    pick_src;
    logic          rx_elig;

    rr_arbiter #(.N(NR), .PW(PW)) u_rr (
        .req     (rx_req),
        .ptr     (rr_ptr),
        .any_req (rx_any),
        .idx     (rx_idx)
    );

    always_comb begin
        rx_elig = run & rx_any;
        rx_inc  = {1'b0, rx_idx} + 1'b1;
        rr_next = (rx_inc == NRW) ? '0 : rx_inc[PW-1:0];
        // Starved Rx jumps the non-response classes only
        pick_src = SRC_NONE;
        if (resp_req)                         pick_src = SRC_RESP;
        else if (rx_elig && starve_cnt == SL) pick_src = SRC_RX;
        else if (run && cc_req)               pick_src = SRC_CC;
        else if (run && mic_req)              pick_src = SRC_MIC;
        else if (run && wideband && wb_req)   pick_src = SRC_WB;
        else if (rx_elig)                     pick_src = SRC_RX;
    end

    always_ff @(posedge tx_clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            grant_valid   <= 1'b0;
            grant_src     <= SRC_NONE;
            grant_rx      <= '0;
            sched_timeout <= 1'b0;
            rr_ptr        <= '0;
            starve_cnt    <= '0;
            to_cnt        <= '0;
            gap_cnt       <= '0;
        end else begin
            sched_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_src != SRC_NONE) begin
                        grant_valid <= 1'b1;
                        grant_src   <= pick_src;
                        grant_rx    <= (pick_src == SRC_RX) ? RXW'(rx_idx) : '0;
                        state       <= ST_GRANT;
                    end
                    if (!run) begin
                        rr_ptr     <= '0;
                        starve_cnt <= '0;
                    end else if (pick_src == SRC_RX) begin
                        rr_ptr     <= rr_next;
                        starve_cnt <= '0;
                    end else if (!rx_any) begin
                        starve_cnt <= '0;
                    end else if (pick_src != SRC_NONE && starve_cnt != SL) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                ST_GRANT: begin
                    to_cnt <= '0;
                    state  <= ST_BUSY;
                end
                ST_BUSY: begin
                    // A done arriving on the timeout cycle wins: no timeout pulse
                    if (send_done || to_cnt == TO_LAST) begin
                        grant_valid   <= 1'b0;
                        grant_src     <= SRC_NONE;
                        grant_rx      <= '0;
                        gap_cnt       <= '0;
                        sched_timeout <= !send_done;
                        state         <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                        if (!send_done) to_cnt <= TO_FULL;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GL) state <= ST_IDLE;
                    else               gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Randomized and directed bench for udp_tx_scheduler against a transaction-level model.
module tb_udp_tx_scheduler;
    import udp_tx_sched_pkg::*;

    localparam int NR  = 8;
    localparam int SL  = 4;
    localparam int GAP = 2;
    localparam int TO  = 4095;
    localparam int RXW = $clog2(NR) + 1;

    logic          tx_clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          run = 1'b0, wideband = 1'b0;
    logic          resp_req = 1'b0, cc_req = 1'b0, mic_req = 1'b0, wb_req = 1'b0;
    logic [NR-1:0] rx_req = '0;
    logic          send_done = 1'b0;
    logic          grant_valid;
    logic [2:0]    grant_src;
    logic [RXW-1:0] grant_rx;
    logic          sched_timeout;

    int n_cmp = 0;
    int n_bad = 0;
    int m_rr = 0;
    int m_st = 0;

    always #5 tx_clock = ~tx_clock;

    udp_tx_scheduler #(.NR(NR), .STARVE_LIMIT(SL), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
        .tx_clock      (tx_clock),
        .reset_n       (reset_n),
        .run           (run),
        .wideband      (wideband),
        .resp_req      (resp_req),
        .cc_req        (cc_req),
        .mic_req       (mic_req),
        .wb_req        (wb_req),
        .rx_req        (rx_req),
        .send_done     (send_done),
        .grant_valid   (grant_valid),
        .grant_src     (grant_src),
        .grant_rx      (grant_rx),
        .sched_timeout (sched_timeout)
    );

    // Which packet the rules say goes next, given the requests currently held.
    task automatic model_decide(output logic [2:0] src, output int idx);
        logic [NR-1:0] tmp;
        bit rx_ok;
        int first;
        if (!run) begin m_rr = 0; m_st = 0; end
        if (rx_req == '0) m_st = 0;
        rx_ok = run && (rx_req != '0);
        first = 0;
        for (int k = NR - 1; k >= 0; k--) begin
            tmp = rx_req >> ((m_rr + k) % NR);
            if (tmp[0]) first = (m_rr + k) % NR;
        end
        idx = 0;
        if (resp_req)                     src = SRC_RESP;
        else if (rx_ok && m_st == SL)     src = SRC_RX;
        else if (run && cc_req)           src = SRC_CC;
        else if (run && mic_req)          src = SRC_MIC;
        else if (run && wideband && wb_req) src = SRC_WB;
        else if (rx_ok)                   src = SRC_RX;
        else                              src = SRC_NONE;
        if (src == SRC_RX) begin
            idx = first; m_st = 0; m_rr = (first + 1) % NR;
        end else if (src != SRC_NONE && run && rx_req != '0) begin
            m_st = (m_st < SL) ? m_st + 1 : SL;
        end
    endtask

    task automatic model_idle_clear();
        if (!run) begin m_rr = 0; m_st = 0; end
        if (rx_req == '0) m_st = 0;
    endtask

    task automatic wait_grant(input int bound, output int lat);
        lat = -1;
        for (int k = 1; k <= bound; k++) begin
            @(posedge tx_clock); #1;
            if (grant_valid) begin lat = k; break; end
        end
    endtask

    task automatic pulse_done(input int hold, output logic gv_after, output logic to_after);
        repeat (hold + 1) @(posedge tx_clock);
        #1 send_done = 1'b1;
        @(posedge tx_clock); #1;
        send_done = 1'b0;
        gv_after = grant_valid;
        to_after = sched_timeout;
    endtask

    task automatic hard_reset();
        reset_n = 1'b0;
        run = 0; wideband = 0; resp_req = 0; cc_req = 0; mic_req = 0; wb_req = 0;
        rx_req = '0; send_done = 0;
        repeat (2) @(posedge tx_clock);
        #1;
        m_rr = 0; m_st = 0;
    endtask

    task automatic randomize_reqs();
        run      = ($urandom_range(0, 3) != 0);
        wideband = $urandom_range(0, 1) == 1;
        resp_req = ($urandom_range(0, 4) == 0);
        cc_req   = ($urandom_range(0, 2) == 0);
        mic_req  = ($urandom_range(0, 2) == 0);
        wb_req   = ($urandom_range(0, 2) == 0);
        rx_req   = NR'($urandom & $urandom);
        if (!resp_req && !(run && (cc_req || mic_req || (wideband && wb_req) || rx_req != '0)))
            resp_req = 1'b1;
    endtask

    task automatic test_reset();
        hard_reset();
        run = 1; cc_req = 1; rx_req = '1;
        #2;
        n_cmp++;
        if ({grant_valid, grant_src, grant_rx, sched_timeout} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got gv=%0d src=%0d rx=%0d to=%0d required all 0",
                     grant_valid, grant_src, grant_rx, sched_timeout);
        end
    endtask

    task automatic test_priority();
        logic [2:0] es; int ei, lat; logic gv, to;
        hard_reset();
        run = 1; cc_req = 1; mic_req = 1;
        reset_n = 1'b1;
        model_decide(es, ei);
        wait_grant(10, lat);
        n_cmp++;
        if (lat != 1 || grant_src !== SRC_CC) begin
            n_bad++; $display("FAIL prio_first: got lat=%0d src=%0d required lat=1 src=%0d", lat, grant_src, SRC_CC);
        end
        cc_req = 0;
        @(posedge tx_clock); #1;
        n_cmp++;
        if (!grant_valid || grant_src !== SRC_CC) begin
            n_bad++; $display("FAIL req_drop_hold: got gv=%0d src=%0d required gv=1 src=%0d", grant_valid, grant_src, SRC_CC);
        end
        pulse_done(0, gv, to);
        n_cmp++;
        if (gv !== 1'b0) begin
            n_bad++; $display("FAIL done_close: got gv=%0d required 0", gv);
        end
        model_decide(es, ei);
        wait_grant(10, lat);
        n_cmp++;
        if (lat != GAP + 1 || grant_src !== es || es !== SRC_MIC) begin
            n_bad++; $display("FAIL prio_second: got lat=%0d src=%0d required lat=%0d src=%0d", lat, grant_src, GAP + 1, SRC_MIC);
        end
        pulse_done(0, gv, to);
    endtask

    task automatic test_rx_round_robin();
        logic [2:0] es; int ei, lat; logic gv, to;
        hard_reset();
        run = 1; rx_req = '1;
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            model_decide(es, ei);
            wait_grant(10, lat);
            n_cmp++;
            if (lat != ((i == 0) ? 1 : GAP + 1) || grant_src !== SRC_RX || grant_rx !== RXW'(i % NR)) begin
                n_bad++; $display("FAIL rr_seq[%0d]: got lat=%0d src=%0d rx=%0d required src=%0d rx=%0d",
                                  i, lat, grant_src, grant_rx, SRC_RX, i % NR);
            end
            pulse_done(i % 3, gv, to);
        end
    endtask

    task automatic test_starvation();
        logic [2:0] es, want; int ei, lat; logic gv, to;
        hard_reset();
        run = 1; cc_req = 1; rx_req = NR'(8'h08);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            want = (i % 5 == 4) ? SRC_RX : SRC_CC;
            model_decide(es, ei);
            wait_grant(10, lat);
            n_cmp++;
            if (lat < 0 || grant_src !== want || (want == SRC_RX && grant_rx !== RXW'(3))) begin
                n_bad++; $display("FAIL starve[%0d]: got src=%0d rx=%0d required src=%0d rx=3",
                                  i, grant_src, grant_rx, want);
            end
            pulse_done(0, gv, to);
        end
    endtask

    task automatic test_run_gate();
        logic [2:0] es; int ei, lat; logic gv, to;
        hard_reset();
        resp_req = 1; cc_req = 1; rx_req = NR'(8'h81);
        reset_n = 1'b1;
        model_decide(es, ei);
        wait_grant(10, lat);
        n_cmp++;
        if (lat != 1 || grant_src !== SRC_RESP) begin
            n_bad++; $display("FAIL run_gate_resp: got lat=%0d src=%0d required lat=1 src=%0d", lat, grant_src, SRC_RESP);
        end
        resp_req = 0;
        pulse_done(1, gv, to);
        wait_grant(12, lat);
        n_cmp++;
        if (lat != -1) begin
            n_bad++; $display("FAIL run_gate_block: got grant src=%0d required none", grant_src);
        end
        model_idle_clear();
        run = 1;
        model_decide(es, ei);
        wait_grant(5, lat);
        n_cmp++;
        if (lat != 1 || grant_src !== SRC_CC) begin
            n_bad++; $display("FAIL run_gate_cc: got lat=%0d src=%0d required lat=1 src=%0d", lat, grant_src, SRC_CC);
        end
        pulse_done(0, gv, to);
    endtask

    task automatic test_timeout();
        logic [2:0] es; int ei, lat, cnt; logic gv, to;
        hard_reset();
        run = 1; mic_req = 1;
        reset_n = 1'b1;
        model_decide(es, ei);
        wait_grant(10, lat);
        cnt = 1;
        for (int k = 0; k < TO + 20; k++) begin
            @(posedge tx_clock); #1;
            if (grant_valid) cnt++;
            else break;
        end
        n_cmp++;
        if (cnt != TO + 1 || sched_timeout !== 1'b1) begin
            n_bad++; $display("FAIL timeout_close: got open=%0d pulse=%0d required open=%0d pulse=1", cnt, sched_timeout, TO + 1);
        end
        @(posedge tx_clock); #1;
        n_cmp++;
        if (sched_timeout !== 1'b0) begin
            n_bad++; $display("FAIL timeout_pulse_width: got %0d required 0", sched_timeout);
        end
        model_decide(es, ei);
        wait_grant(10, lat);
        n_cmp++;
        if (lat != GAP || grant_src !== SRC_MIC) begin
            n_bad++; $display("FAIL timeout_next: got lat=%0d src=%0d required lat=%0d src=%0d", lat, grant_src, GAP, SRC_MIC);
        end
        pulse_done(2, gv, to);
        n_cmp++;
        if (gv !== 1'b0 || to !== 1'b0) begin
            n_bad++; $display("FAIL timeout_normal_done: got gv=%0d to=%0d required 0 0", gv, to);
        end
    endtask

    task automatic test_done_ignored();
        logic [2:0] es; int ei, lat; logic gv, to;
        hard_reset();
        run = 1; wideband = 1; wb_req = 1;
        reset_n = 1'b1;
        model_decide(es, ei);
        wait_grant(10, lat);
        send_done = 1'b1;
        @(posedge tx_clock); #1;
        send_done = 1'b0;
        @(posedge tx_clock); #1;
        n_cmp++;
        if (!grant_valid || grant_src !== SRC_WB) begin
            n_bad++; $display("FAIL done_in_grant: got gv=%0d src=%0d required gv=1 src=%0d", grant_valid, grant_src, SRC_WB);
        end
        wideband = 0;
        pulse_done(0, gv, to);
        send_done = 1'b1;
        @(posedge tx_clock); #1;
        send_done = 1'b0;
        wait_grant(10, lat);
        n_cmp++;
        if (lat != -1) begin
            n_bad++; $display("FAIL wb_gate: got grant src=%0d required none", grant_src);
        end
        wideband = 1;
        model_decide(es, ei);
        wait_grant(5, lat);
        n_cmp++;
        if (lat != 1 || grant_src !== SRC_WB) begin
            n_bad++; $display("FAIL wb_enable: got lat=%0d src=%0d required lat=1 src=%0d", lat, grant_src, SRC_WB);
        end
        pulse_done(0, gv, to);
    endtask

    task automatic test_reset_mid_packet();
        logic [2:0] es; int ei, lat;
        hard_reset();
        run = 1; rx_req = NR'(8'h20);
        reset_n = 1'b1;
        model_decide(es, ei);
        wait_grant(10, lat);
        n_cmp++;
        if (lat != 1 || grant_src !== SRC_RX || grant_rx !== RXW'(ei)) begin
            n_bad++; $display("FAIL mid_rst_grant: got src=%0d rx=%0d required src=%0d rx=%0d", grant_src, grant_rx, SRC_RX, ei);
        end
        @(posedge tx_clock); #3;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (grant_valid !== 1'b0) begin
            n_bad++; $display("FAIL mid_rst_async: got gv=%0d required 0", grant_valid);
        end
        rx_req = NR'(8'h01);
        m_rr = 0; m_st = 0;
        @(posedge tx_clock); #1;
        reset_n = 1'b1;
        model_decide(es, ei);
        wait_grant(10, lat);
        n_cmp++;
        if (lat != 1 || grant_src !== SRC_RX || grant_rx !== RXW'(0)) begin
            n_bad++; $display("FAIL mid_rst_after: got lat=%0d src=%0d rx=%0d required lat=1 src=%0d rx=0", lat, grant_src, grant_rx, SRC_RX);
        end
    endtask

    task automatic test_random();
        logic [2:0] es; int ei, lat, exp_lat; logic gv, to;
        hard_reset();
        randomize_reqs();
        reset_n = 1'b1;
        exp_lat = 1;
        for (int i = 0; i < 80; i++) begin
            model_decide(es, ei);
            wait_grant(10, lat);
            n_cmp++;
            if (lat != exp_lat || grant_src !== es || (es == SRC_RX && grant_rx !== RXW'(ei))) begin
                n_bad++; $display("FAIL random[%0d]: got lat=%0d src=%0d rx=%0d required lat=%0d src=%0d rx=%0d",
                                  i, lat, grant_src, grant_rx, exp_lat, es, ei);
            end
            randomize_reqs();
            pulse_done($urandom_range(0, 3), gv, to);
            n_cmp++;
            if (gv !== 1'b0 || to !== 1'b0) begin
                n_bad++; $display("FAIL random_done[%0d]: got gv=%0d to=%0d required 0 0", i, gv, to);
            end
            exp_lat = GAP + 1;
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_rx_round_robin();
        test_starvation();
        test_run_gate();
        test_timeout();
        test_done_ignored();
        test_reset_mid_packet();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
